// File: rtl/prince_pkg.sv
// Constants, S-box tables, nibble permutations and state encoding for the
// iterative PRINCE core.
package prince_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

   function automatic logic [63:0] rc(input logic [3:0] idx);
      logic [63:0] r;
      case (idx)
         4'd1:    r = 64'h13198a2e03707344;
         4'd2:    r = 64'ha4093822299f31d0;
         4'd3:    r = 64'h082efa98ec4e6c89;
         4'd4:    r = 64'h452821e638d01377;
         4'd5:    r = 64'hbe5466cf34e90c6c;
         4'd6:    r = 64'h7ef84f78fd955cb1;
         4'd7:    r = 64'h85840851f1ac43aa;
         4'd8:    r = 64'hc882d32f25323c54;
         4'd9:    r = 64'h64a51195e0e3610d;
         4'd10:   r = 64'hd3b5a399ca0c2399;
         4'd11:   r = 64'hc0ac29b7c97c50dd;
         default: r = 64'h0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hb;  4'h1: y = 4'hf;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
         4'h4: y = 4'ha;  4'h5: y = 4'hc;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
         4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'ha: y = 4'h8;  4'hb: y = 4'h0;
         4'hc: y = 4'he;  4'hd: y = 4'h5;  4'he: y = 4'hd;  default: y = 4'h4;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hb;  4'h1: y = 4'h7;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
         4'h4: y = 4'hf;  4'h5: y = 4'hd;  4'h6: y = 4'h8;  4'h7: y = 4'h9;
         4'h8: y = 4'ha;  4'h9: y = 4'h6;  4'ha: y = 4'h4;  4'hb: y = 4'h0;
         4'hc: y = 4'h5;  4'hd: y = 4'he;  4'he: y = 4'hc;  default: y = 4'h1;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 16; j++) y[4*j +: 4] = sbox(x[4*j +: 4]);
      return y;
   endfunction

   function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 16; j++) y[4*j +: 4] = sbox_inv(x[4*j +: 4]);
      return y;
   endfunction

   // Source nibble for output nibble j of ShiftRows (nibble 0 = bits 63:60).
   function automatic logic [3:0] sr_src(input logic [3:0] j);
      logic [3:0] p;
      case (j)
         4'd0:  p = 4'd0;   4'd1:  p = 4'd5;   4'd2:  p = 4'd10;  4'd3:  p = 4'd15;
         4'd4:  p = 4'd4;   4'd5:  p = 4'd9;   4'd6:  p = 4'd14;  4'd7:  p = 4'd3;
         4'd8:  p = 4'd8;   4'd9:  p = 4'd13;  4'd10: p = 4'd2;   4'd11: p = 4'd7;
         4'd12: p = 4'd12;  4'd13: p = 4'd1;   4'd14: p = 4'd6;   default: p = 4'd11;
      endcase
      return p;
   endfunction

   function automatic logic [63:0] shift_rows(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 16; j++)
         y[63-4*j -: 4] = x[63-4*int'(sr_src(4'(j))) -: 4];
      return y;
   endfunction

   function automatic logic [63:0] shift_rows_inv(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 16; j++)
         y[63-4*int'(sr_src(4'(j))) -: 4] = x[63-4*j -: 4];
      return y;
   endfunction

endpackage

// File: rtl/M.sv
// PRINCE M' linear layer: block-diagonal (M0, M1, M1, M0) over 16-bit chunks.
// It is an involution, so the same block serves both directions.
module M (
   input  logic [63:0] x,
   output logic [63:0] y
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_chunk
      // Outer chunks use M0, inner chunks use M1 (block pattern shifted by one).
      localparam int OFF = (gi == 0 || gi == 3) ? 0 : 1;
      logic [15:0] cx;
      logic [15:0] cy;

      assign cx = x[63-16*gi -: 16];

      always_comb begin
         cy = '0;
         for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++)
               for (int j = 0; j < 4; j++)
                  if (((i + j + OFF) % 4) != b)
                     cy[15-4*i-b] = cy[15-4*i-b] ^ cx[15-4*j-b];
      end

      assign y[63-16*gi -: 16] = cy;
   end

endmodule

// File: rtl/prince_enc_iter.sv
// Iterative PRINCE encrypt/decrypt core: one round per clock with valid/ready
// handshakes; decryption reuses the encrypt datapath via alpha-reflection.
module prince_enc_iter
   import prince_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_data,
   input  logic [127:0] in_key,
   input  logic         in_dec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data
);

   state_t      state_reg;
   logic [3:0]  rnd_reg;
   logic [63:0] s_reg;
   logic [63:0] kb_reg;
   logic [63:0] kc_reg;

   logic [63:0] k0, k1, k0p;
   logic [63:0] ka_sel, kb_sel, kc_sel;

   assign k0  = in_key[127:64];
   assign k1  = in_key[63:0];
   assign k0p = {k0[0], k0[63:1]} ^ (k0 >> 63);

   assign ka_sel = in_dec ? k0p : k0;
   assign kb_sel = in_dec ? k0 : k0p;
   assign kc_sel = in_dec ? (k1 ^ ALPHA) : k1;

   logic [63:0] fwd_sub, m_fwd, fwd_next, mid_next;
   logic [63:0] bwd_pre, bwd_perm, m_bwd, bwd_next;

   assign fwd_sub  = s_layer(s_reg);
   M u_m_fwd (.x(fwd_sub), .y(m_fwd));
   assign fwd_next = shift_rows(m_fwd) ^ rc(rnd_reg) ^ kc_reg;
   assign mid_next = s_inv_layer(m_fwd);

   // Backward round is the exact inverse of a forward round: undo SR before M'.
   assign bwd_pre  = s_reg ^ rc(rnd_reg - 4'd1) ^ kc_reg;
   assign bwd_perm = shift_rows_inv(bwd_pre);
   M u_m_bwd (.x(bwd_perm), .y(m_bwd));
   assign bwd_next = s_inv_layer(m_bwd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         rnd_reg   <= 4'd0;
         s_reg     <= '0;
         kb_reg    <= '0;
         kc_reg    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  kb_reg    <= kb_sel;
                  kc_reg    <= kc_sel;
                  s_reg     <= in_data ^ ka_sel ^ kc_sel ^ rc(4'd0);
                  rnd_reg   <= 4'd1;
                  in_ready  <= 1'b0;
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (rnd_reg <= 4'd5)
                  s_reg <= fwd_next;
               else if (rnd_reg == 4'd6)
                  s_reg <= mid_next;
               else
                  s_reg <= bwd_next;

               if (rnd_reg == 4'd11) begin
                  out_data  <= bwd_next ^ rc(4'd11) ^ kc_reg ^ kb_reg;
                  out_valid <= 1'b1;
                  rnd_reg   <= 4'd0;
                  state_reg <= ST_DONE;
               end else begin
                  rnd_reg <= rnd_reg + 4'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
